// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings, colour-bar table and default
// active-area geometry (also used by vga_controller).
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam int HACTIVE_DEF = 640;
    localparam int VACTIVE_DEF = 480;

    // {R,G,B} on/off per bar index; index 0 (white) is the rightmost entry.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing stream in / pixel stream out of the pattern generator.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4
);
    logic                   hs_in;
    logic                   vs_in;
    logic                   de_in;
    logic [1:0]             mode;
    logic [3*COLOR_W-1:0]   solid_rgb;
    logic [COLOR_W-1:0]     VGA_R;
    logic [COLOR_W-1:0]     VGA_G;
    logic [COLOR_W-1:0]     VGA_B;
    logic                   VGA_HS;
    logic                   VGA_VS;
    logic                   de_out;

    modport master (
        output hs_in, vs_in, de_in, mode, solid_rgb,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, de_out
    );

    modport slave (
        input  hs_in, vs_in, de_in, mode, solid_rgb,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, de_out
    );
endinterface

// File: rtl/vga_pos_tracker.sv
// Recovers the active-pixel position, frame count and colour-bar index from
// the controller's sync/enable stream. Outputs describe the pixel now on de_in.
module vga_pos_tracker #(
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int COLOR_W = 4,
    localparam int XW     = $clog2(HACTIVE),
    localparam int YW     = $clog2(VACTIVE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs_in,
    input  logic               de_in,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [COLOR_W-1:0] frame_cnt,
    output logic [2:0]         bar_idx,
    output logic               vs_fall
);
    localparam int BAR_W = HACTIVE / 8;
    localparam int BW    = $clog2(BAR_W);

    logic               de_prev_reg, vs_prev_reg;
    logic [XW-1:0]      x_reg, x_next;
    logic [YW-1:0]      y_reg, y_next;
    logic [COLOR_W-1:0] frame_reg, frame_next;
    logic [2:0]         bar_idx_reg, bar_idx_next;
    logic [BW-1:0]      bar_sub_reg, bar_sub_next;
    logic               de_fall;

    assign de_fall = de_prev_reg & ~de_in;
    assign vs_fall = vs_prev_reg & ~vs_in;

    // Registers hold the values for the pixel being presented; next-values
    // prepare the following pixel.
    always_comb begin
        x_next       = de_in ? x_reg + 1'b1 : '0;
        y_next       = y_reg;
        frame_next   = frame_reg + COLOR_W'(vs_fall);
        bar_sub_next = '0;
        bar_idx_next = '0;
        if (!vs_in)
            y_next = '0;
        else if (de_fall && y_reg != YW'(VACTIVE - 1))
            y_next = y_reg + 1'b1;
        if (de_in) begin
            bar_idx_next = bar_idx_reg;
            if (bar_sub_reg == BW'(BAR_W - 1)) begin
                bar_sub_next = '0;
                if (bar_idx_reg != 3'd7)
                    bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
                bar_sub_next = bar_sub_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
            frame_reg   <= '0;
            bar_idx_reg <= '0;
            bar_sub_reg <= '0;
        end else begin
            de_prev_reg <= de_in;
            vs_prev_reg <= vs_in;
            x_reg       <= x_next;
            y_reg       <= y_next;
            frame_reg   <= frame_next;
            bar_idx_reg <= bar_idx_next;
            bar_sub_reg <= bar_sub_next;
        end
    end

    assign x         = x_reg;
    assign y         = y_reg;
    assign frame_cnt = frame_reg;
    assign bar_idx   = bar_idx_reg;
endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: per-frame mode latch, pattern mux and a single
// output register stage keeping RGB aligned with the delayed syncs.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int HACTIVE  = HACTIVE_DEF,
    parameter int VACTIVE  = VACTIVE_DEF,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5
) (
    input  logic              pixel_clk,
    input  logic              rst,
    vga_pattern_gen_if.slave  bus
);
    localparam int XW = $clog2(HACTIVE);
    localparam int YW = $clog2(VACTIVE);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [COLOR_W-1:0]   frame_cnt;
    logic [2:0]           bar_idx;
    logic                 vs_fall;
    logic [2:0]           bar_bits;
    mode_t                mode_reg;
    logic [3*COLOR_W-1:0] rgb_reg, rgb_next;
    logic                 hs_reg, vs_reg, de_reg;

    vga_pos_tracker #(
        .HACTIVE (HACTIVE),
        .VACTIVE (VACTIVE),
        .COLOR_W (COLOR_W)
    ) u_pos (
        .clk       (pixel_clk),
        .rst       (rst),
        .vs_in     (bus.vs_in),
        .de_in     (bus.de_in),
        .x         (x),
        .y         (y),
        .frame_cnt (frame_cnt),
        .bar_idx   (bar_idx),
        .vs_fall   (vs_fall)
    );

    assign bar_bits = BAR_RGB[bar_idx];

    always_comb begin
        rgb_next = '0;
        if (bus.de_in) begin
            case (mode_reg)
                MODE_BARS:  rgb_next = {{COLOR_W{bar_bits[2]}},
                                        {COLOR_W{bar_bits[1]}},
                                        {COLOR_W{bar_bits[0]}}};
                MODE_CHECK: rgb_next = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? '0 : '1;
                MODE_GRAD:  rgb_next = {COLOR_W'(x >> (XW - COLOR_W)),
                                        COLOR_W'(y >> (YW - COLOR_W)),
                                        frame_cnt};
                MODE_SOLID: rgb_next = bus.solid_rgb;
                default:    rgb_next = '0;
            endcase
        end
    end

    // Mode only changes at the start of vertical sync so a frame is never split.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            mode_reg <= MODE_BARS;
            rgb_reg  <= '0;
            hs_reg   <= 1'b0;
            vs_reg   <= 1'b0;
            de_reg   <= 1'b0;
        end else begin
            if (vs_fall)
                mode_reg <= mode_t'(bus.mode);
            rgb_reg <= rgb_next;
            hs_reg  <= bus.hs_in;
            vs_reg  <= bus.vs_in;
            de_reg  <= bus.de_in;
        end
    end

    assign bus.VGA_R  = rgb_reg[3*COLOR_W-1:2*COLOR_W];
    assign bus.VGA_G  = rgb_reg[2*COLOR_W-1:COLOR_W];
    assign bus.VGA_B  = rgb_reg[COLOR_W-1:0];
    assign bus.VGA_HS = hs_reg;
    assign bus.VGA_VS = vs_reg;
    assign bus.de_out = de_reg;
endmodule
